// File: rtl/fp_wb_pkg.sv
// Shared constants and types for the FP register file write path.
package fp_wb_pkg;
    localparam int FPREG_AW = 5;
    localparam int FPREG_DW = 32;
    localparam int FPREG_N  = 32;

    typedef logic [FPREG_AW-1:0] fpreg_addr_t;
endpackage

// File: rtl/fp_wb_arbiter_rr_arbiter.sv
// Combinational round-robin picker: the first requester at or after ptr
// (wrapping modulo N) wins.
module rr_arbiter #(
    parameter int  N  = 3,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    input  logic          en,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] idx
);
    // cand[k] is the requester examined at priority position k.
    logic [PW-1:0] cand [N];

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_cand
            assign cand[gi] = (int'(ptr) + gi >= N) ? PW'(int'(ptr) + gi - N)
                                                    : PW'(int'(ptr) + gi);
        end
    endgenerate

    always_comb begin
        grant = '0;
        idx   = '0;
        // Scan from lowest priority up so the highest-priority hit is kept.
        for (int k = N - 1; k >= 0; k--) begin
            if (req[cand[k]]) begin
                idx = cand[k];
            end
        end
        if (en && (|req)) begin
            grant[idx] = 1'b1;
        end
    end
endmodule

// File: rtl/fp_wb_arbiter.sv
// Round-robin arbitration of NREQ result producers onto the single FP
// register file write port, with a one-cycle registered output stage.
import fp_wb_pkg::*;

module fp_wb_arbiter #(
    parameter int  NREQ = 3,
    parameter int  AW   = FPREG_AW,
    parameter int  DW   = FPREG_DW,
    localparam int PW   = $clog2(NREQ)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               hold,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]    req_ready,
    output logic               fwe,
    output logic [AW-1:0]      fwa3,
    output logic [DW-1:0]      fwd3,
    output logic [FPREG_N-1:0] pend_mask,
    output logic [PW-1:0]      rr_ptr
);
    logic [PW-1:0]   rr_ptr_reg;
    logic [PW-1:0]   rr_ptr_next;
    logic            fwe_reg;
    logic [AW-1:0]   fwa3_reg;
    logic [DW-1:0]   fwd3_reg;
    logic [NREQ-1:0] grant;
    logic [PW-1:0]   gidx;
    logic            xfer;
    logic [AW-1:0]   sel_addr;
    logic [DW-1:0]   sel_data;

    rr_arbiter #(.N(NREQ)) u_rr_arbiter (
        .req   (req_valid),
        .ptr   (rr_ptr_reg),
        .en    (~reset & ~hold),
        .grant (grant),
        .idx   (gidx)
    );

    assign req_ready   = grant;
    assign xfer        = |grant;
    assign sel_addr    = req_addr[int'(gidx)*AW +: AW];
    assign sel_data    = req_data[int'(gidx)*DW +: DW];
    assign rr_ptr_next = (int'(gidx) == NREQ - 1) ? '0 : gidx + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr_reg <= '0;
            fwe_reg    <= 1'b0;
            fwa3_reg   <= '0;
            fwd3_reg   <= '0;
        end else begin
            // f0 is hardwired to zero, so its writes are accepted but never issued.
            fwe_reg <= xfer && (sel_addr != '0);
            if (xfer) begin
                rr_ptr_reg <= rr_ptr_next;
                fwa3_reg   <= sel_addr;
                fwd3_reg   <= sel_data;
            end
        end
    end

    // A write sitting in the output stage when reset arrives must not land.
    assign fwe    = fwe_reg & ~reset;
    assign fwa3   = fwa3_reg;
    assign fwd3   = fwd3_reg;
    assign rr_ptr = rr_ptr_reg;

    always_comb begin
        pend_mask = '0;
        if (fwe) begin
            pend_mask[fwa3_reg] = 1'b1;
        end
    end
endmodule

// File: tb/tb_fp_wb_arbiter.sv
// Directed and randomized checks of fp_wb_arbiter against a behavioural model.
module tb_fp_wb_arbiter;
    localparam int NREQ = 3;
    localparam int AW   = 5;
    localparam int DW   = 32;

    logic               clk = 1'b0;
    logic               reset;
    logic               hold;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    req_ready;
    logic               fwe;
    logic [AW-1:0]      fwa3;
    logic [DW-1:0]      fwd3;
    logic [31:0]        pend_mask;
    logic [1:0]         rr_ptr;

    int n_cmp  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    // Behavioural model state
    int          m_ptr  = 0;
    bit          m_fwe  = 1'b0;
    logic [4:0]  m_fwa3 = '0;
    logic [31:0] m_fwd3 = '0;

    always #5 clk = ~clk;

    fp_wb_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
        .clk       (clk),
        .reset     (reset),
        .hold      (hold),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_ready (req_ready),
        .fwe       (fwe),
        .fwa3      (fwa3),
        .fwd3      (fwd3),
        .pend_mask (pend_mask),
        .rr_ptr    (rr_ptr)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Winner index per round-robin rule, or -1 when nothing may be granted.
    function automatic int pick(int p, logic [NREQ-1:0] v, logic h, logic r);
        if (h || r) return -1;
        for (int k = 0; k < NREQ; k++) begin
            if (v[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return -1;
    endfunction

    always @(posedge clk) begin
        int w;
        w = pick(m_ptr, req_valid, hold, reset);
        if (reset) begin
            m_ptr = 0; m_fwe = 0; m_fwa3 = '0; m_fwd3 = '0;
        end else if (w >= 0) begin
            m_ptr  = (w + 1) % NREQ;
            m_fwa3 = req_addr[w*AW +: AW];
            m_fwd3 = req_data[w*DW +: DW];
            m_fwe  = (m_fwa3 != 0);
        end else begin
            m_fwe = 0;
        end
    end

    always @(negedge clk) begin
        int          w;
        logic [2:0]  er;
        logic [31:0] ep;
        if (chk_en) begin
            w  = pick(m_ptr, req_valid, hold, reset);
            er = (w < 0) ? 3'b000 : 3'(1 << w);
            ep = (m_fwe && !reset) ? (32'h1 << m_fwa3) : 32'h0;
            chk("m_req_ready", 32'(req_ready), 32'(er));
            chk("m_rr_ptr", 32'(rr_ptr), 32'(m_ptr));
            chk("m_fwe", 32'(fwe), 32'(m_fwe && !reset));
            chk("m_fwa3", 32'(fwa3), 32'(m_fwa3));
            chk("m_fwd3", fwd3, m_fwd3);
            chk("m_pend_mask", pend_mask, ep);
        end
    end

    task automatic set_req(input int i, input logic v, input logic [4:0] a, input logic [31:0] d);
        req_valid[i]          = v;
        req_addr[i*AW +: AW]  = a;
        req_data[i*DW +: DW]  = d;
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [NREQ-1:0] hs;
        reset = 1'b1; hold = 1'b0; req_valid = '0; req_addr = '0; req_data = '0;
        nxt();
        chk_en = 1'b1;
        nxt();
        reset = 1'b0;

        // Idle after reset
        repeat (10) begin
            @(negedge clk);
            chk("idle_fwe", 32'(fwe), 32'h0);
            chk("idle_ptr", 32'(rr_ptr), 32'h0);
            chk("idle_ready", 32'(req_ready), 32'h0);
            chk("idle_pend", pend_mask, 32'h0);
            nxt();
        end

        // Single transfer
        set_req(0, 1'b1, 5'd5, 32'h3F800000);
        @(negedge clk); chk("single_ready", 32'(req_ready), 32'h1);
        nxt(); req_valid = '0;
        @(negedge clk);
        chk("single_fwe", 32'(fwe), 32'h1);
        chk("single_fwa3", 32'(fwa3), 32'd5);
        chk("single_fwd3", fwd3, 32'h3F800000);
        chk("single_pend", pend_mask, 32'h00000020);
        chk("single_ptr", 32'(rr_ptr), 32'h1);

        nxt(); reset = 1'b1;
        nxt(); reset = 1'b0;

        // All three requesters continuously valid
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 5'(i + 1), 32'h1000 + i);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("rr_ready", 32'(req_ready), 32'h1 << (k % 3));
            if (k > 0) begin
                chk("rr_fwe", 32'(fwe), 32'h1);
                chk("rr_fwa3", 32'(fwa3), 32'((k - 1) % 3 + 1));
            end
            nxt();
        end
        req_valid = '0;
        @(negedge clk);
        chk("rr_last_fwa3", 32'(fwa3), 32'd3);
        chk("rr_last_ptr", 32'(rr_ptr), 32'h0);

        // Write to f0
        nxt(); set_req(1, 1'b1, 5'd0, 32'hDEADBEEF);
        @(negedge clk); chk("f0_ready", 32'(req_ready), 32'h2);
        nxt(); req_valid = '0;
        @(negedge clk);
        chk("f0_fwe", 32'(fwe), 32'h0);
        chk("f0_pend", pend_mask, 32'h0);
        chk("f0_ptr", 32'(rr_ptr), 32'h2);

        // hold with pointer at 2
        nxt(); req_valid = 3'b111; hold = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("hold_ready", 32'(req_ready), 32'h0);
            chk("hold_ptr", 32'(rr_ptr), 32'h2);
            nxt();
        end
        hold = 1'b0;
        @(negedge clk); chk("unhold_ready", 32'(req_ready), 32'h4);
        nxt(); req_valid = '0;
        @(negedge clk); chk("unhold_ptr", 32'(rr_ptr), 32'h0);

        // Reset right after a grant to f7
        nxt(); set_req(0, 1'b1, 5'd7, 32'h77777777);
        @(negedge clk); chk("rst_ready", 32'(req_ready), 32'h1);
        nxt(); reset = 1'b1;
        @(negedge clk);
        chk("rst_cycle_fwe", 32'(fwe), 32'h0);
        chk("rst_cycle_ready", 32'(req_ready), 32'h0);
        nxt(); reset = 1'b0; req_valid = '0;
        @(negedge clk);
        chk("rst_after_fwe", 32'(fwe), 32'h0);
        chk("rst_after_ptr", 32'(rr_ptr), 32'h0);

        // Randomized traffic obeying the hold-until-handshake rule
        repeat (3000) begin
            @(negedge clk);
            hs = req_valid & req_ready;
            nxt();
            hold  = ($urandom_range(0, 6) == 0);
            reset = ($urandom_range(0, 99) == 0);
            for (int i = 0; i < NREQ; i++) begin
                if (!req_valid[i] || hs[i]) begin
                    logic [4:0] a;
                    a = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
                    set_req(i, ($urandom_range(0, 2) != 0), a, $urandom);
                end
            end
        end

        nxt(); reset = 1'b0; hold = 1'b0; req_valid = '0;
        repeat (3) nxt();
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/fp_wb_arbiter.md
Name: fp_wb_arbiter

Overview:
- Shares the single write port of the FP register file (fwe/fwa3/fwd3) between NREQ result producers, e.g. FP add unit, FP multiply unit, FP load (lwc1) and mtc1.
- Each producer offers one register write per handshake. A round-robin arbiter grants at most one write per cycle.
- The granted write is registered and drives the register file port one cycle later.
- The block sits between the FP execution/writeback sources and the FP register file.

Parameters:
- NREQ, 3, number of requesters; legal range 2..8.
- AW, 5, register address width; fixed by the 32-entry FP register file.
- DW, 32, data width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- hold  in  1  when 1, no grants are issued this cycle (writeback stall).
- req_valid  in  NREQ  per-requester write request.
- req_addr  in  NREQ*AW  flattened destination registers; requester i uses bits [i*AW +: AW].
- req_data  in  NREQ*DW  flattened write data; requester i uses bits [i*DW +: DW].
- req_ready  out  NREQ  one-hot or zero grant; combinational.
- fwe  out  1  register file write enable; registered.
- fwa3  out  AW  register file write address; registered.
- fwd3  out  DW  register file write data; registered.
- pend_mask  out  32  bit fwa3 set when fwe=1, else all zero; used for hazard detection.
- rr_ptr  out  clog2(NREQ)  current highest-priority requester; for debug and verification.

Behaviour:
- Reset: rr_ptr=0, fwe=0, fwa3=0, fwd3=0, pend_mask=0. req_ready is 0 during any cycle with reset=1.
- Grant selection (combinational): scan requesters starting at rr_ptr and wrapping modulo NREQ. The first one with req_valid=1 wins, and its req_ready goes high.
- No grant is issued if hold=1, reset=1, or req_valid is all zero.
- Handshake: a transfer occurs in any cycle with req_valid[i] & req_ready[i].
- Requirement on requesters: once a requester raises valid, it keeps valid, addr and data stable until that handshake cycle. The arbiter does not check this.
- At most one req_ready bit is high in any cycle.
- Pointer update: on a transfer by requester i, rr_ptr <= (i+1) mod NREQ. With no transfer, rr_ptr is unchanged.
- Fairness: a continuously valid requester is granted within NREQ non-hold cycles.
- Output stage: on a transfer, the next cycle drives fwe=1, fwa3=addr_i, fwd3=data_i. Latency from handshake to the register file write edge is 1 cycle. With no transfer, fwe=0 next cycle and fwa3/fwd3 keep their old values.
- Register 0: a transfer with addr=0 is accepted normally (ready, pointer advance) but produces fwe=0, because f0 is hardwired to zero. pend_mask stays 0 in that case.
- Same-address requests in one cycle: they are serialised in round-robin order. The later grant overwrites the earlier one in the register file.
- hold: freezes grants and rr_ptr only. A write already in the output stage still completes (fwe is not gated by hold).
- Reset while a write is in the output stage: the write is dropped (fwe=0 next cycle), and no requester sees a completed handshake after reset.
- NREQ not a power of two: rr_ptr wraps from NREQ-1 to 0 and never holds values of NREQ or above.

Decomposition:
- Package fp_wb_pkg: FPREG_AW=5, FPREG_DW=32, FPREG_N=32, and the typedef fpreg_addr_t.
- One natural sub-module: rr_arbiter (parameter N; inputs: req vector, ptr, enable; outputs: one-hot grant and granted index).
- fp_wb_arbiter adds the pointer register, the data mux and the output register.

Test Plan:
- Reset, then idle with all valid=0 -> fwe=0, rr_ptr=0, req_ready=000, pend_mask=0 for 10 cycles.
- Single transfer: req_valid=001, addr0=5, data0=0x3F800000 -> req_ready=001 in cycle T; at T+1 fwe=1, fwa3=5, fwd3=0x3F800000, pend_mask=0x00000020; rr_ptr=1.
- All three requesters valid for 6 cycles (addrs 1/2/3) -> grants in order 0,1,2,0,1,2; every write appears on fwe one cycle after its grant.
- Write to f0: addr1=0, data1=0xDEADBEEF -> req_ready[1]=1 and rr_ptr advances, but fwe=0 and pend_mask=0 next cycle.
- hold=1 for 3 cycles with req_valid=111 and rr_ptr=2 -> req_ready=000 and rr_ptr stays 2. After hold drops, requester 2 is granted first.
- reset asserted in the cycle after a grant to addr=7 -> fwe=0 the next cycle and rr_ptr=0. The reg7 write never reaches the register file.
